// File: rtl/dispatch_unit.sv
// In-order single-issue dispatch stage: renames operands, steers each
// instruction to the RS or LSB and allocates a ROB entry, one per cycle.
module dispatch_unit #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned REG_IDX_W = 5,
   parameter int unsigned ROB_IDX_W = 6,
   parameter int unsigned ROB_DEPTH = 64,
   parameter int unsigned OPC_W     = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_pc,
   input  logic                 in_jumped,
   input  logic                 in_is_mem,
   input  logic [OPC_W-1:0]     in_opcode,
   input  logic [REG_IDX_W-1:0] in_rs1,
   input  logic [REG_IDX_W-1:0] in_rs2,
   input  logic [REG_IDX_W-1:0] in_rd,
   input  logic [XLEN-1:0]      in_imm,
   input  logic                 rob_full,
   input  logic                 rs_full,
   input  logic                 lsb_full,
   output logic [REG_IDX_W-1:0] rf_check1,
   output logic [REG_IDX_W-1:0] rf_check2,
   input  logic [XLEN-1:0]      rf_val1,
   input  logic [XLEN-1:0]      rf_val2,
   input  logic                 rf_has_dep1,
   input  logic                 rf_has_dep2,
   input  logic [ROB_IDX_W-1:0] rf_dep1,
   input  logic [ROB_IDX_W-1:0] rf_dep2,
   output logic [ROB_IDX_W-1:0] rob_check1,
   output logic [ROB_IDX_W-1:0] rob_check2,
   input  logic                 rob_value_valid1,
   input  logic                 rob_value_valid2,
   input  logic [XLEN-1:0]      rob_value1,
   input  logic [XLEN-1:0]      rob_value2,
   input  logic                 cdb_valid,
   input  logic [ROB_IDX_W-1:0] cdb_rob_index,
   input  logic [XLEN-1:0]      cdb_value,
   output logic                 rob_valid,
   output logic [ROB_IDX_W-1:0] rob_index,
   output logic [REG_IDX_W-1:0] rob_rd,
   output logic [OPC_W-1:0]     rob_opcode,
   output logic [XLEN-1:0]      rob_pc,
   output logic                 rob_jumped,
   output logic                 rs_valid,
   output logic                 lsb_valid,
   output logic [OPC_W-1:0]     op_opcode,
   output logic [XLEN-1:0]      op_val1,
   output logic [XLEN-1:0]      op_val2,
   output logic                 op_has_dep1,
   output logic                 op_has_dep2,
   output logic [ROB_IDX_W-1:0] op_dep1,
   output logic [ROB_IDX_W-1:0] op_dep2,
   output logic [XLEN-1:0]      op_imm,
   output logic [XLEN-1:0]      op_pc,
   output logic [ROB_IDX_W-1:0] op_rob_index,
   output logic                 rf_valid,
   output logic [REG_IDX_W-1:0] rf_regname,
   output logic [ROB_IDX_W-1:0] rf_regrename
);

   typedef struct packed {
      logic [XLEN-1:0]      val;
      logic                 has_dep;
      logic [ROB_IDX_W-1:0] dep;
   } opnd_t;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] next_idx;
      logic                 last_valid;
      logic [REG_IDX_W-1:0] last_rd;
      logic [ROB_IDX_W-1:0] last_tag;
      logic                 rob_valid;
      logic                 rs_valid;
      logic                 lsb_valid;
      logic                 rf_valid;
      logic [ROB_IDX_W-1:0] idx;
      logic [REG_IDX_W-1:0] rd;
      logic [OPC_W-1:0]     opcode;
      logic [XLEN-1:0]      pc;
      logic                 jumped;
      logic [XLEN-1:0]      imm;
      opnd_t                op1;
      opnd_t                op2;
   } state_t;

   state_t state_d, state_q;
   opnd_t  res1, res2;
   logic   issue;

   // Operand lookup: x0, then the instruction issued last cycle (its rename is
   // not yet visible in the RF), then the RF rename table; a tag is resolved
   // through the CDB first and, for RF tags only, through the ROB.
   function automatic opnd_t resolve(
      input logic [REG_IDX_W-1:0] rs,
      input logic                 rf_hd,
      input logic [ROB_IDX_W-1:0] rf_d,
      input logic [XLEN-1:0]      rf_v,
      input logic                 rob_vv,
      input logic [XLEN-1:0]      rob_v
   );
      opnd_t                o;
      logic [ROB_IDX_W-1:0] tag;
      logic                 has_tag;
      logic                 from_rf;
      o       = '0;
      tag     = rf_d;
      has_tag = 1'b0;
      from_rf = 1'b0;
      if (rs != '0) begin
         if (state_q.last_valid && rs == state_q.last_rd) begin
            tag     = state_q.last_tag;
            has_tag = 1'b1;
         end else if (rf_hd) begin
            has_tag = 1'b1;
            from_rf = 1'b1;
         end else begin
            o.val = rf_v;
         end
      end
      if (has_tag) begin
         if (cdb_valid && cdb_rob_index == tag) begin
            o.val = cdb_value;
         end else if (from_rf && rob_vv) begin
            o.val = rob_v;
         end else begin
            o.has_dep = 1'b1;
            o.dep     = tag;
         end
      end
      return o;
   endfunction

   // Handshake and operand resolution.
   always_comb begin
      in_ready = rdy & ~rst & ~flush & ~rob_full & (in_is_mem ? ~lsb_full : ~rs_full);
      issue    = in_valid & in_ready;
      res1     = resolve(in_rs1, rf_has_dep1, rf_dep1, rf_val1, rob_value_valid1, rob_value1);
      res2     = resolve(in_rs2, rf_has_dep2, rf_dep2, rf_val2, rob_value_valid2, rob_value2);
   end

   // Next state: hold when stalled by rdy, clear on flush, capture on issue.
   always_comb begin
      state_d = state_q;
      if (rdy) begin
         if (flush) begin
            state_d = '0;
         end else begin
            state_d.rob_valid  = issue;
            state_d.rs_valid   = issue & ~in_is_mem;
            state_d.lsb_valid  = issue & in_is_mem;
            state_d.rf_valid   = issue & (in_rd != '0);
            state_d.last_valid = issue & (in_rd != '0);
            if (issue) begin
               state_d.next_idx = (state_q.next_idx == ROB_IDX_W'(ROB_DEPTH - 1)) ?
                                  '0 : state_q.next_idx + ROB_IDX_W'(1);
               state_d.last_rd  = in_rd;
               state_d.last_tag = state_q.next_idx;
               state_d.idx      = state_q.next_idx;
               state_d.rd       = in_rd;
               state_d.opcode   = in_opcode;
               state_d.pc       = in_pc;
               state_d.jumped   = in_jumped;
               state_d.imm      = in_imm;
               state_d.op1      = res1;
               state_d.op2      = res2;
            end
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign rf_check1    = in_rs1;
   assign rf_check2    = in_rs2;
   assign rob_check1   = rf_dep1;
   assign rob_check2   = rf_dep2;
   assign rob_valid    = state_q.rob_valid;
   assign rob_index    = state_q.idx;
   assign rob_rd       = state_q.rd;
   assign rob_opcode   = state_q.opcode;
   assign rob_pc       = state_q.pc;
   assign rob_jumped   = state_q.jumped;
   assign rs_valid     = state_q.rs_valid;
   assign lsb_valid    = state_q.lsb_valid;
   assign op_opcode    = state_q.opcode;
   assign op_val1      = state_q.op1.val;
   assign op_val2      = state_q.op2.val;
   assign op_has_dep1  = state_q.op1.has_dep;
   assign op_has_dep2  = state_q.op2.has_dep;
   assign op_dep1      = state_q.op1.dep;
   assign op_dep2      = state_q.op2.dep;
   assign op_imm       = state_q.imm;
   assign op_pc        = state_q.pc;
   assign op_rob_index = state_q.idx;
   assign rf_valid     = state_q.rf_valid;
   assign rf_regname   = state_q.rd;
   assign rf_regrename = state_q.idx;

endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboard bench for dispatch_unit: the driver pushes hand-computed expected
// dispatch results, a monitor pops and compares whenever a strobe appears.
module tb_dispatch_unit;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned ROB_IDX_W = 6;
   localparam int unsigned ROB_DEPTH = 48;
   localparam int unsigned OPC_W     = 6;

   logic clk, rst, rdy, flush, in_valid, in_ready, in_jumped, in_is_mem;
   logic [XLEN-1:0] in_pc, in_imm, rf_val1, rf_val2, rob_value1, rob_value2, cdb_value;
   logic [OPC_W-1:0] in_opcode, rob_opcode, op_opcode;
   logic [REG_IDX_W-1:0] in_rs1, in_rs2, in_rd, rf_check1, rf_check2, rob_rd, rf_regname;
   logic rob_full, rs_full, lsb_full, rf_has_dep1, rf_has_dep2;
   logic [ROB_IDX_W-1:0] rf_dep1, rf_dep2, rob_check1, rob_check2, cdb_rob_index;
   logic rob_value_valid1, rob_value_valid2, cdb_valid;
   logic rob_valid, rob_jumped, rs_valid, lsb_valid, op_has_dep1, op_has_dep2, rf_valid;
   logic [ROB_IDX_W-1:0] rob_index, op_dep1, op_dep2, op_rob_index, rf_regrename;
   logic [XLEN-1:0] rob_pc, op_val1, op_val2, op_imm, op_pc;

   dispatch_unit #(
      .XLEN(XLEN), .REG_IDX_W(REG_IDX_W), .ROB_IDX_W(ROB_IDX_W),
      .ROB_DEPTH(ROB_DEPTH), .OPC_W(OPC_W)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_jumped(in_jumped),
      .in_is_mem(in_is_mem), .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rd(in_rd), .in_imm(in_imm), .rob_full(rob_full), .rs_full(rs_full),
      .lsb_full(lsb_full), .rf_check1(rf_check1), .rf_check2(rf_check2),
      .rf_val1(rf_val1), .rf_val2(rf_val2), .rf_has_dep1(rf_has_dep1),
      .rf_has_dep2(rf_has_dep2), .rf_dep1(rf_dep1), .rf_dep2(rf_dep2),
      .rob_check1(rob_check1), .rob_check2(rob_check2),
      .rob_value_valid1(rob_value_valid1), .rob_value_valid2(rob_value_valid2),
      .rob_value1(rob_value1), .rob_value2(rob_value2), .cdb_valid(cdb_valid),
      .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value), .rob_valid(rob_valid),
      .rob_index(rob_index), .rob_rd(rob_rd), .rob_opcode(rob_opcode), .rob_pc(rob_pc),
      .rob_jumped(rob_jumped), .rs_valid(rs_valid), .lsb_valid(lsb_valid),
      .op_opcode(op_opcode), .op_val1(op_val1), .op_val2(op_val2),
      .op_has_dep1(op_has_dep1), .op_has_dep2(op_has_dep2), .op_dep1(op_dep1),
      .op_dep2(op_dep2), .op_imm(op_imm), .op_pc(op_pc), .op_rob_index(op_rob_index),
      .rf_valid(rf_valid), .rf_regname(rf_regname), .rf_regrename(rf_regrename)
   );

   typedef struct packed {
      logic                 is_mem, rob_full, rs_full, lsb_full;
      logic [REG_IDX_W-1:0] rd, rs1, rs2;
      logic [XLEN-1:0]      pc, rf_v1, rf_v2, rob_v1, rob_v2, cdb_val;
      logic                 rf_hd1, rf_hd2, rob_vv1, rob_vv2, cdb_v;
      logic [ROB_IDX_W-1:0] rf_d1, rf_d2, cdb_idx;
   } stim_t;

   typedef struct packed {
      logic                 rob_v;
      logic [ROB_IDX_W-1:0] idx;
      logic                 rs_v, lsb_v, rf_v;
      logic [REG_IDX_W-1:0] rd;
      logic [ROB_IDX_W-1:0] rename;
      logic [XLEN-1:0]      v1;
      logic                 hd1;
      logic [ROB_IDX_W-1:0] d1;
      logic [XLEN-1:0]      v2;
      logic                 hd2;
      logic [ROB_IDX_W-1:0] d2;
      logic [XLEN-1:0]      pc;
   } exp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic stim_t mk(input int rd, input int rs1, input int rs2, input int pc);
      stim_t s;
      s     = '0;
      s.rd  = REG_IDX_W'(rd);
      s.rs1 = REG_IDX_W'(rs1);
      s.rs2 = REG_IDX_W'(rs2);
      s.pc  = XLEN'(pc);
      return s;
   endfunction

   function automatic exp_t ex(input int idx, input bit is_mem, input int rd,
                               input logic [31:0] v1, input bit hd1, input int d1,
                               input logic [31:0] v2, input bit hd2, input int d2,
                               input int pc);
      exp_t e;
      e.rob_v  = 1'b1;
      e.idx    = ROB_IDX_W'(idx);
      e.rs_v   = ~is_mem;
      e.lsb_v  = is_mem;
      e.rf_v   = (rd != 0);
      e.rd     = REG_IDX_W'(rd);
      e.rename = ROB_IDX_W'(idx);
      e.v1     = v1;
      e.hd1    = hd1;
      e.d1     = ROB_IDX_W'(d1);
      e.v2     = v2;
      e.hd2    = hd2;
      e.d2     = ROB_IDX_W'(d2);
      e.pc     = XLEN'(pc);
      return e;
   endfunction

   // Called just after a rising edge; returns just after the following one.
   task automatic drive(input stim_t s, input bit acc, input exp_t e);
      in_valid = 1'b1;         in_is_mem = s.is_mem;   in_rd = s.rd;
      in_rs1 = s.rs1;          in_rs2 = s.rs2;         in_pc = s.pc;
      in_opcode = 6'h13;       in_imm = 32'h4;         in_jumped = 1'b0;
      rob_full = s.rob_full;   rs_full = s.rs_full;    lsb_full = s.lsb_full;
      rf_val1 = s.rf_v1;       rf_val2 = s.rf_v2;
      rf_has_dep1 = s.rf_hd1;  rf_has_dep2 = s.rf_hd2;
      rf_dep1 = s.rf_d1;       rf_dep2 = s.rf_d2;
      rob_value_valid1 = s.rob_vv1; rob_value_valid2 = s.rob_vv2;
      rob_value1 = s.rob_v1;   rob_value2 = s.rob_v2;
      cdb_valid = s.cdb_v;     cdb_rob_index = s.cdb_idx; cdb_value = s.cdb_val;
      @(negedge clk);
      chk("in_ready", in_ready, acc);
      chk("rf_check1", rf_check1, s.rs1);
      chk("rob_check2", rob_check2, s.rf_d2);
      if (acc) q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0; cdb_valid = 1'b0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: each strobe cycle after an enabled edge is one dispatch result.
   initial begin
      logic       rdy_e, rst_e;
      logic [3:0] strb, prev;
      exp_t       act, e;
      prev = '0;
      forever begin
         @(posedge clk);
         rdy_e = rdy;
         rst_e = rst;
         @(negedge clk);
         strb = {rob_valid, rs_valid, lsb_valid, rf_valid};
         if (rst_e) begin
            chk("reset_strobes", strb, 4'b0);
         end else if (!rdy_e) begin
            chk("rdy_low_hold", strb, prev);
         end else if (strb != 4'b0) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_dispatch: got strobes %b, required none", strb);
            end else begin
               e   = q.pop_front();
               act = {rob_valid, rob_index, rs_valid, lsb_valid, rf_valid, rf_regname,
                      rf_regrename, op_val1, op_has_dep1, op_dep1, op_val2, op_has_dep2,
                      op_dep2, rob_pc};
               if (act !== e) begin
                  n_fail++;
                  $display("FAIL dispatch_idx%0d: got %h, required %h", e.idx, act, e);
               end
            end
         end
         prev = strb;
      end
   end

   initial begin
      stim_t s;
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      in_valid = 1'b0; in_is_mem = 1'b0; in_pc = '0; in_jumped = 1'b0; in_opcode = '0;
      in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
      rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
      rf_val1 = '0; rf_val2 = '0; rf_has_dep1 = 1'b0; rf_has_dep2 = 1'b0;
      rf_dep1 = '0; rf_dep2 = '0; rob_value_valid1 = 1'b0; rob_value_valid2 = 1'b0;
      rob_value1 = '0; rob_value2 = '0; cdb_valid = 1'b0; cdb_rob_index = '0; cdb_value = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1'b0);
      chk("reset_outputs", {rob_valid, rs_valid, lsb_valid, rf_valid, rob_index,
                            op_val1, op_has_dep1, rf_regname}, 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // x0 sources read as zero regardless of RF contents.
      s = mk(5, 0, 0, 32'h100); s.rf_v1 = 32'h1111; s.rf_v2 = 32'h2222;
      drive(s, 1'b1, ex(0, 0, 5, 0, 0, 0, 0, 0, 0, 32'h100));
      for (int i = 1; i < 7; i++) drive(mk(0, 0, 0, i * 4), 1'b1, ex(i, 0, 0, 0, 0, 0, 0, 0, 0, i * 4));
      drive(mk(3, 0, 0, 32'h1c), 1'b1, ex(7, 0, 3, 0, 0, 0, 0, 0, 0, 32'h1c));
      // Back-to-back: rs1 hits the just-issued rd=3 even though the RF shows no rename.
      s = mk(6, 3, 4, 32'h20); s.rf_v1 = 32'h55; s.rf_v2 = 32'h44;
      drive(s, 1'b1, ex(8, 0, 6, 0, 1, 7, 32'h44, 0, 0, 32'h20));
      idle(1);
      // After an idle cycle the RF value is used.
      s = mk(0, 6, 0, 32'h24); s.rf_v1 = 32'h66;
      drive(s, 1'b1, ex(9, 0, 0, 32'h66, 0, 0, 0, 0, 0, 32'h24));
      drive(mk(9, 0, 0, 32'h28), 1'b1, ex(10, 0, 9, 0, 0, 0, 0, 0, 0, 32'h28));
      // Last-issued wins over RF rename and ROB value.
      s = mk(0, 9, 0, 32'h2c); s.rf_hd1 = 1; s.rf_d1 = 20; s.rob_vv1 = 1; s.rob_v1 = 32'h77;
      drive(s, 1'b1, ex(11, 0, 0, 0, 1, 10, 0, 0, 0, 32'h2c));
      // CDB forwarding hit.
      s = mk(0, 2, 0, 32'h30); s.rf_hd1 = 1; s.rf_d1 = 12;
      s.cdb_v = 1; s.cdb_idx = 12; s.cdb_val = 32'hDEAD;
      drive(s, 1'b1, ex(12, 0, 0, 32'hDEAD, 0, 0, 0, 0, 0, 32'h30));
      // CDB miss keeps the dep; operand 2 picks up a completed ROB value.
      s = mk(0, 2, 4, 32'h34); s.rf_hd1 = 1; s.rf_d1 = 12;
      s.cdb_v = 1; s.cdb_idx = 13; s.cdb_val = 32'hDEAD;
      s.rf_hd2 = 1; s.rf_d2 = 30; s.rob_vv2 = 1; s.rob_v2 = 32'hBEEF;
      drive(s, 1'b1, ex(13, 0, 0, 0, 1, 12, 32'hBEEF, 0, 0, 32'h34));
      // Steering and back-pressure.
      s = mk(0, 0, 0, 32'h38); s.is_mem = 1; s.lsb_full = 1;
      drive(s, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      s.is_mem = 0;
      drive(s, 1'b1, ex(14, 0, 0, 0, 0, 0, 0, 0, 0, 32'h38));
      s = mk(0, 0, 0, 32'h3c); s.is_mem = 1; s.rs_full = 1;
      drive(s, 1'b1, ex(15, 1, 0, 0, 0, 0, 0, 0, 0, 32'h3c));
      s = mk(0, 0, 0, 32'h40); s.rob_full = 1;
      drive(s, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive(mk(0, 0, 0, 32'h40), 1'b1, ex(16, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40));
      // rdy low: no acceptance, outputs frozen.
      rdy = 1'b0;
      drive(mk(0, 0, 0, 32'h44), 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive(mk(0, 0, 0, 32'h44), 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rdy = 1'b1;
      for (int i = 17; i < 48; i++) drive(mk(0, 0, 0, i * 4), 1'b1, ex(i, 0, 0, 0, 0, 0, 0, 0, 0, i * 4));
      // Wrap at ROB_DEPTH-1.
      drive(mk(8, 0, 0, 32'h200), 1'b1, ex(0, 0, 8, 0, 0, 0, 0, 0, 0, 32'h200));
      flush = 1'b1;
      s = mk(0, 8, 0, 32'h204); s.rf_v1 = 32'h88;
      drive(s, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      flush = 1'b0;
      // Flush restarts allocation at 0 and drops forwarding of rd=8.
      drive(s, 1'b1, ex(0, 0, 0, 32'h88, 0, 0, 0, 0, 0, 32'h204));
      idle(3);
      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
